trap_ctrl: RTL and testbench

Trap sequencer between the execute stage and the CSR register file. It accepts one trap-class event per request: a synchronous exception or an `mret`. For exceptions it drives the CSR file's exception-capture inputs, then redirects fetch to the trap vector. For `mret` it reads `mepc` through the CSR read port and redirects fetch there. The core stalls while the block is busy.

---
 rtl/trap_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer between the execute stage and the CSR file.
// Exceptions are reported to the CSR file, then fetch is redirected to the
// trap vector; mret reads mepc and redirects fetch there. Busy stalls the core.
module trap_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [11:0] MEPC_ADDR = 12'h341
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_instr,
    input  logic [31:0] req_addr,
    input  logic [6:0]  req_flags,
    output logic        exception,
    output logic [3:0]  exception_code,
    output logic [31:0] exception_pc,
    output logic [31:0] exception_val,
    input  logic [31:0] trap_vector,
    output logic        csr_read_en,
    output logic [11:0] csr_read_addr,
    input  logic [31:0] csr_read_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic [31:0] trap_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTER    = 2'd1,
        MRET_RD  = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;

    // Request resolution (combinational, from the live request)
    logic        exc_any;
    logic        is_mret;
    logic [3:0]  exc_code;
    logic [31:0] exc_val;
    logic        accept;

    // Latched exception record and redirect target
    logic [3:0]  code_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] addr_q;
    logic [31:0] val_q;
    logic [31:0] target_q;
    logic [31:0] trap_count_q;

    assign accept  = (state == IDLE) && req_valid;
    assign exc_any = |req_flags[5:0];
    assign is_mret = req_flags[6];

    // Priority-resolve the exception cause and its tval
    always_comb begin
        exc_code = '0;
        exc_val  = '0;
        if (req_flags[0]) begin
            exc_code = 4'd0;
            exc_val  = req_addr;
        end else if (req_flags[1]) begin
            exc_code = 4'd2;
            exc_val  = req_instr;
        end else if (req_flags[2]) begin
            exc_code = 4'd3;
            exc_val  = req_pc;
        end else if (req_flags[3]) begin
            exc_code = 4'd11;
            exc_val  = '0;
        end else if (req_flags[4]) begin
            exc_code = 4'd4;
            exc_val  = req_addr;
        end else if (req_flags[5]) begin
            exc_code = 4'd6;
            exc_val  = req_addr;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; an exception flag overrides a simultaneous mret
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (exc_any) begin
                        state_nx = ENTER;
                    end else if (is_mret) begin
                        state_nx = MRET_RD;
                    end
                end
            end
            ENTER:    state_nx = REDIRECT;
            MRET_RD:  state_nx = REDIRECT;
            REDIRECT: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Latch the request on accept, capture the redirect target, count traps
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q       <= '0;
            pc_q         <= '0;
            instr_q      <= '0;
            addr_q       <= '0;
            val_q        <= '0;
            target_q     <= RESET_PC;
            trap_count_q <= '0;
        end else begin
            if (accept) begin
                pc_q    <= req_pc;
                instr_q <= req_instr;
                addr_q  <= req_addr;
                code_q  <= exc_code;
                val_q   <= exc_val;
            end
            if (state == ENTER) begin
                target_q     <= {trap_vector[31:2], 2'b00};
                trap_count_q <= trap_count_q + 32'd1;
            end
            if (state == MRET_RD) begin
                target_q <= {csr_read_data[31:2], 2'b00};
            end
        end
    end

    // Output decode from the current state
    always_comb begin
        req_ready      = 1'b0;
        exception      = 1'b0;
        exception_code = '0;
        exception_pc   = '0;
        exception_val  = '0;
        csr_read_en    = 1'b0;
        csr_read_addr  = '0;
        redirect_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
            end
            ENTER: begin
                exception      = 1'b1;
                exception_code = code_q;
                exception_pc   = pc_q;
                exception_val  = val_q;
            end
            MRET_RD: begin
                csr_read_en   = 1'b1;
                csr_read_addr = MEPC_ADDR;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign busy        = ~req_ready;
    assign redirect_pc = target_q;
    assign trap_count  = trap_count_q;

    // instr_q/addr_q are kept for debug visibility of the accepted request
    logic unused_ok;
    assign unused_ok = ^{instr_q, addr_q};

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: randomized and directed checks of trap_ctrl against a
// cycle-timeline reference model.
module tb_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic [31:0] req_instr;
    logic [31:0] req_addr;
    logic [6:0]  req_flags;
    logic        exception;
    logic [3:0]  exception_code;
    logic [31:0] exception_pc;
    logic [31:0] exception_val;
    logic [31:0] trap_vector;
    logic        csr_read_en;
    logic [11:0] csr_read_addr;
    logic [31:0] csr_read_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [31:0] trap_count;

    trap_ctrl #(.RESET_PC(32'h8000_0000), .MEPC_ADDR(12'h341)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .req_instr(req_instr), .req_addr(req_addr), .req_flags(req_flags),
        .exception(exception), .exception_code(exception_code),
        .exception_pc(exception_pc), .exception_val(exception_val),
        .trap_vector(trap_vector),
        .csr_read_en(csr_read_en), .csr_read_addr(csr_read_addr), .csr_read_data(csr_read_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .trap_count(trap_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model (event timeline by cycle number) ----
    longint      cyc = 0;
    longint      ready_from = 0;
    longint      exc_cyc = -10;
    longint      rd_cyc = -10;
    longint      redir_cyc = -10;
    logic [3:0]  m_code = '0;
    logic [31:0] m_epc = '0;
    logic [31:0] m_val = '0;
    logic [31:0] m_target = 32'h8000_0000;
    logic [31:0] m_count = '0;
    bit          m_init = 1'b0;

    initial begin
        int codes [6];
        codes = '{0, 2, 3, 11, 4, 6};
        forever begin
            @(posedge clk);
            if (rst) begin
                ready_from = cyc + 1;
                exc_cyc    = -10;
                rd_cyc     = -10;
                redir_cyc  = -10;
                m_target   = 32'h8000_0000;
                m_count    = '0;
                m_init     = 1'b1;
            end else begin
                if (cyc == exc_cyc) begin
                    m_target = trap_vector & 32'hFFFF_FFFC;
                    m_count  = m_count + 32'd1;
                end
                if (cyc == rd_cyc)
                    m_target = csr_read_data & 32'hFFFF_FFFC;
                if (cyc >= ready_from && req_valid) begin
                    if (req_flags[5:0] != 6'd0) begin
                        for (int i = 5; i >= 0; i--) begin
                            if (req_flags[i]) begin
                                m_code = 4'(codes[i]);
                                m_val  = (i == 1) ? req_instr :
                                         (i == 2) ? req_pc :
                                         (i == 3) ? 32'd0 : req_addr;
                            end
                        end
                        m_epc      = req_pc;
                        exc_cyc    = cyc + 1;
                        redir_cyc  = cyc + 2;
                        ready_from = cyc + 3;
                    end else if (req_flags[6]) begin
                        rd_cyc     = cyc + 1;
                        redir_cyc  = cyc + 2;
                        ready_from = cyc + 3;
                    end
                end
            end
            cyc = cyc + 1;
        end
    end

    // ---------------- checking ----------------
    int          checks = 0;
    int          failures = 0;
    logic [31:0] count_offset = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output to the model
    task automatic tick();
        bit e_exc;
        @(negedge clk);
        if (m_init) begin
            e_exc = (cyc == exc_cyc);
            check("req_ready", 32'(req_ready), 32'(cyc >= ready_from));
            check("busy", 32'(busy), 32'(cyc < ready_from));
            check("exception", 32'(exception), 32'(e_exc));
            check("exception_code", 32'(exception_code), e_exc ? 32'(m_code) : 32'd0);
            check("exception_pc", exception_pc, e_exc ? m_epc : 32'd0);
            check("exception_val", exception_val, e_exc ? m_val : 32'd0);
            check("csr_read_en", 32'(csr_read_en), 32'(cyc == rd_cyc));
            check("csr_read_addr", 32'(csr_read_addr), (cyc == rd_cyc) ? 32'h341 : 32'd0);
            check("redirect_valid", 32'(redirect_valid), 32'(cyc == redir_cyc));
            check("redirect_pc", redirect_pc, m_target);
            check("trap_count", trap_count, m_count + count_offset);
        end
    endtask

    // Present a request, wait (bounded) for acceptance, return in cycle N+1
    task automatic send(input logic [6:0] f, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [31:0] ad);
        req_flags = f;
        req_pc    = pc;
        req_instr = ins;
        req_addr  = ad;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) tick();
        check("accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int          r;
        logic [6:0]  f;
        rst = 1'b1;
        req_valid = 1'b0;
        req_pc = '0;
        req_instr = '0;
        req_addr = '0;
        req_flags = '0;
        trap_vector = 32'h8000_0403;
        csr_read_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("lit_reset_ready", 32'(req_ready), 32'd1);
        check("lit_reset_redirect_pc", redirect_pc, 32'h8000_0000);
        check("lit_reset_count", trap_count, 32'd0);

        // ecall
        send(7'b0001000, 32'h8000_0100, 32'h0000_0073, 32'h55);
        check("lit_ecall_exc", 32'(exception), 32'd1);
        check("lit_ecall_code", 32'(exception_code), 32'd11);
        check("lit_ecall_pc", exception_pc, 32'h8000_0100);
        check("lit_ecall_val", exception_val, 32'd0);
        tick();
        check("lit_ecall_redir", 32'(redirect_valid), 32'd1);
        check("lit_ecall_target", redirect_pc, 32'h8000_0400);
        check("lit_ecall_count", trap_count, 32'd1);
        tick();

        // illegal
        send(7'b0000010, 32'h8000_0110, 32'hFFFF_FFFF, 32'h0);
        check("lit_illegal_code", 32'(exception_code), 32'd2);
        check("lit_illegal_val", exception_val, 32'hFFFF_FFFF);
        tick(); tick();

        // misaligned fetch beats illegal
        send(7'b0000011, 32'h8000_0120, 32'h1, 32'h1234_5679);
        check("lit_prio_code", 32'(exception_code), 32'd0);
        check("lit_prio_val", exception_val, 32'h1234_5679);
        tick(); tick();

        // ebreak with mret: exception wins, no CSR read
        send(7'b1000100, 32'h8000_0300, 32'h0010_0073, 32'h0);
        check("lit_ebrk_code", 32'(exception_code), 32'd3);
        check("lit_ebrk_val", exception_val, 32'h8000_0300);
        check("lit_ebrk_no_csr", 32'(csr_read_en), 32'd0);
        tick(); tick();

        // mret
        csr_read_data = 32'h8000_0206;
        send(7'b1000000, 32'h8000_0130, 32'h3020_0073, 32'h0);
        check("lit_mret_rd_en", 32'(csr_read_en), 32'd1);
        check("lit_mret_rd_addr", 32'(csr_read_addr), 32'h341);
        check("lit_mret_no_exc", 32'(exception), 32'd0);
        tick();
        check("lit_mret_redir", 32'(redirect_valid), 32'd1);
        check("lit_mret_target", redirect_pc, 32'h8000_0204);
        tick();

        // back-to-back with held req_valid
        send(7'b0001000, 32'h8000_0140, 32'h0, 32'h0);
        req_valid = 1'b1;
        req_flags = 7'b0000010;
        req_instr = 32'hDEAD_BEEF;
        check("lit_b2b_ready_n1", 32'(req_ready), 32'd0);
        tick();
        check("lit_b2b_ready_n2", 32'(req_ready), 32'd0);
        tick();
        check("lit_b2b_ready_n3", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("lit_b2b_exc_n4", 32'(exception), 32'd1);
        check("lit_b2b_val_n4", exception_val, 32'hDEAD_BEEF);
        tick(); tick();

        // reset during ENTER
        send(7'b0001000, 32'h8000_0150, 32'h0, 32'h0);
        rst = 1'b1;
        count_offset = '0;
        tick();
        rst = 1'b0;
        check("lit_rst_count", trap_count, 32'd0);
        check("lit_rst_target", redirect_pc, 32'h8000_0000);
        check("lit_rst_redir", 32'(redirect_valid), 32'd0);
        repeat (3) tick();

        // no-flag request is consumed silently
        send(7'b0000000, 32'h8000_0160, 32'h0, 32'h0);
        check("lit_noflag_ready", 32'(req_ready), 32'd1);
        check("lit_noflag_exc", 32'(exception), 32'd0);
        tick();

        // randomized traffic; requester holds the request until accepted
        for (int n = 0; n < 1500; n++) begin
            trap_vector   = $urandom;
            csr_read_data = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                count_offset = '0;
            end else begin
                rst = 1'b0;
            end
            if (!req_valid || req_ready === 1'b0) begin
                if (!req_valid && $urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 9);
                    case (r)
                        0:       f = 7'b0;
                        1:       f = 7'b1000000;
                        7:       f = 7'($urandom);
                        8, 9:    f = 7'b1000000 | (7'd1 << $urandom_range(0, 5));
                        default: f = 7'd1 << $urandom_range(0, 5);
                    endcase
                    req_flags = f;
                    req_pc    = $urandom;
                    req_instr = $urandom;
                    req_addr  = $urandom;
                    req_valid = 1'b1;
                end
            end else begin
                req_valid = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !req_ready; i++) tick();
        tick();

        // wrap: preload the counter to all ones
        force dut.trap_count_q = 32'hFFFF_FFFF;
        count_offset = 32'hFFFF_FFFF - m_count;
        #1;
        release dut.trap_count_q;
        tick();
        check("lit_wrap_pre", trap_count, 32'hFFFF_FFFF);
        send(7'b0001000, 32'h8000_0170, 32'h0, 32'h0);
        tick();
        check("lit_wrap_post", trap_count, 32'd0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
